// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and status-register helpers for the
// SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PROG = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;

  // Bit positions inside the status register byte
  localparam int STAT_WEL  = 1;
  localparam int STAT_BUSY = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    STATUS  = 3'd5,
    IGNORE  = 3'd6
  } state_e;

  // Status byte as seen by RDSR; the array never reports busy because
  // writes complete in a single clk cycle.
  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_WEL]  = wel;
    s[STAT_BUSY] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin followed by a
// one-clk rise/fall pulse generator on the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the pin and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 flash responder: opcode, 24-bit address, then streaming
// read/program of an internal byte array. SPI pins are oversampled in
// the clk domain; a backdoor port preloads and inspects the array.
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int         MEM_AW   = 8,
  parameter logic [7:0] MEM_INIT = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic              wel,
  output logic              busy
);

  localparam int DEPTH = 1 << MEM_AW;
  // Wide enough for an opcode and for the used address bits
  localparam int SHW   = (MEM_AW > 8) ? (MEM_AW - 1) : 7;

  logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;
  logic r_mosi_meta, r_mosi_sync;

  state_e            r_state,     w_state_nxt;
  logic [4:0]        r_bit_cnt,   w_bit_cnt_nxt;
  logic [SHW-1:0]    r_shift,     w_shift_nxt;
  logic              r_is_prog,   w_is_prog_nxt;
  logic [MEM_AW-1:0] r_addr_ptr,  w_addr_ptr_nxt;
  logic [7:0]        r_tx_shift,  w_tx_shift_nxt;
  logic [2:0]        r_tx_cnt,    w_tx_cnt_nxt;
  logic              r_miso,      w_miso_nxt;
  logic              r_wel,       w_wel_nxt;
  logic              r_busy,      w_busy_nxt;
  logic [7:0]        r_bd_rdata;
  logic              w_mem_we;
  logic [7:0]        r_mem [DEPTH];

  logic [7:0]        w_rx_byte;
  logic [MEM_AW-1:0] w_addr_load;
  logic [MEM_AW-1:0] w_ptr_inc;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (spi_cs_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (spi_clk),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // MOSI needs only the synchronizer; it is sampled on SCK rise pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= spi_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  assign w_rx_byte   = {r_shift[6:0], r_mosi_sync};
  assign w_addr_load = {r_shift[MEM_AW-2:0], r_mosi_sync};
  assign w_ptr_inc   = r_addr_ptr + {{(MEM_AW-1){1'b0}}, 1'b1};

  // Next-state and datapath decode; CS release overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_is_prog_nxt  = r_is_prog;
    w_addr_ptr_nxt = r_addr_ptr;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_miso_nxt     = r_miso;
    w_wel_nxt      = r_wel;
    w_busy_nxt     = r_busy;
    w_mem_we       = 1'b0;

    if (w_cs_rise) begin
      w_state_nxt = IDLE;
      w_busy_nxt  = 1'b0;
      w_miso_nxt  = 1'b0;
      // Any PROGRAM, complete or not, consumes the write enable
      if (r_is_prog && ((r_state == ADDR) || (r_state == WR_DATA))) begin
        w_wel_nxt = 1'b0;
      end else begin
        w_wel_nxt = r_wel;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            w_state_nxt   = CMD;
            w_bit_cnt_nxt = 5'd7;
            w_busy_nxt    = 1'b1;
            w_is_prog_nxt = 1'b0;
            w_miso_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        CMD: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[SHW-2:0], r_mosi_sync};
            if (r_bit_cnt == 5'd0) begin
              case (w_rx_byte)
                OP_READ: begin
                  w_state_nxt   = ADDR;
                  w_bit_cnt_nxt = 5'd23;
                  w_is_prog_nxt = 1'b0;
                end
                OP_PROG: begin
                  w_state_nxt   = ADDR;
                  w_bit_cnt_nxt = 5'd23;
                  w_is_prog_nxt = 1'b1;
                end
                OP_RDSR: begin
                  w_state_nxt    = STATUS;
                  w_tx_shift_nxt = status_byte(r_wel);
                  w_tx_cnt_nxt   = 3'd0;
                end
                OP_WREN: begin
                  w_state_nxt = IGNORE;
                  w_wel_nxt   = 1'b1;
                end
                OP_WRDI: begin
                  w_state_nxt = IGNORE;
                  w_wel_nxt   = 1'b0;
                end
                default: w_state_nxt = IGNORE;
              endcase
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - 5'd1;
            end
          end else begin
            w_state_nxt = CMD;
          end
        end
        ADDR: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[SHW-2:0], r_mosi_sync};
            if (r_bit_cnt == 5'd0) begin
              w_addr_ptr_nxt = w_addr_load;
              if (r_is_prog) begin
                w_state_nxt   = WR_DATA;
                w_bit_cnt_nxt = 5'd7;
              end else begin
                w_state_nxt    = RD_DATA;
                w_tx_shift_nxt = r_mem[w_addr_load];
                w_tx_cnt_nxt   = 3'd0;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - 5'd1;
            end
          end else begin
            w_state_nxt = ADDR;
          end
        end
        RD_DATA: begin
          if (w_sck_fall) begin
            w_miso_nxt = r_tx_shift[7];
            if (r_tx_cnt == 3'd7) begin
              w_addr_ptr_nxt = w_ptr_inc;
              w_tx_shift_nxt = r_mem[w_ptr_inc];
              w_tx_cnt_nxt   = 3'd0;
            end else begin
              w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
              w_tx_cnt_nxt   = r_tx_cnt + 3'd1;
            end
          end else begin
            w_state_nxt = RD_DATA;
          end
        end
        WR_DATA: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[SHW-2:0], r_mosi_sync};
            if (r_bit_cnt == 5'd0) begin
              w_bit_cnt_nxt = 5'd7;
              // Without WEL the completed byte is silently dropped
              if (r_wel) begin
                w_mem_we       = 1'b1;
                w_addr_ptr_nxt = w_ptr_inc;
              end else begin
                w_mem_we = 1'b0;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - 5'd1;
            end
          end else begin
            w_state_nxt = WR_DATA;
          end
        end
        STATUS: begin
          if (w_sck_fall) begin
            w_miso_nxt = r_tx_shift[7];
            if (r_tx_cnt == 3'd7) begin
              w_tx_shift_nxt = status_byte(r_wel);
              w_tx_cnt_nxt   = 3'd0;
            end else begin
              w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
              w_tx_cnt_nxt   = r_tx_cnt + 3'd1;
            end
          end else begin
            w_state_nxt = STATUS;
          end
        end
        IGNORE:  w_state_nxt = IGNORE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 5'd0;
      r_shift    <= '0;
      r_is_prog  <= 1'b0;
      r_addr_ptr <= '0;
      r_tx_shift <= 8'h00;
      r_tx_cnt   <= 3'd0;
      r_miso     <= 1'b0;
      r_wel      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_is_prog  <= w_is_prog_nxt;
      r_addr_ptr <= w_addr_ptr_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_miso     <= w_miso_nxt;
      r_wel      <= w_wel_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Byte array; SPI write is applied last so it wins an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= MEM_INIT;
      end
    end else begin
      if (bd_we) begin
        r_mem[bd_addr] <= bd_wdata;
      end
      if (w_mem_we) begin
        r_mem[r_addr_ptr] <= w_rx_byte;
      end
    end
  end

  // Backdoor read port, one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bd_rdata <= 8'h00;
    end else begin
      r_bd_rdata <= r_mem[bd_addr];
    end
  end

  assign spi_miso = r_miso;
  assign bd_rdata = r_bd_rdata;
  assign wel      = r_wel;
  assign busy     = r_busy;

endmodule

// File: doc/spi_flash_target.md
Name: spi_flash_target

Overview:
- Synthesizable SPI flash responder (slave), mode 0, MSB first. It is the far end of the team's SPI flash master controller.
- Decodes an 8-bit opcode, then a 24-bit address, then streams data bytes to or from an internal byte memory.
- Used as an on-chip flash model for SoC bring-up and as a loopback target in master regression.
- The SPI pins are oversampled in the clk domain; a host-side backdoor port preloads and inspects memory.

Parameters:
- MEM_AW, 8, memory address width; depth = 2**MEM_AW bytes; only address bits [MEM_AW-1:0] are used.
- MEM_INIT, 8'hFF, reset/erased value of every memory byte.

Ports:
- clk  in  1  system clock; must be at least 8x the SCK frequency.
- rst_n  in  1  asynchronous reset, active-low.
- spi_cs_n  in  1  chip select, active-low.
- spi_clk  in  1  SCK from the master; idles low.
- spi_mosi  in  1  data from the master.
- spi_miso  out  1  data to the master.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  MEM_AW  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  backdoor read data; registered, 1-cycle latency.
- wel  out  1  write-enable latch state.
- busy  out  1  high while CS is asserted and a transaction is in progress.

Behaviour:
- Reset values: spi_miso=0, bd_rdata=0, wel=0, busy=0, state=IDLE, every memory byte = MEM_INIT.
- Input sync: cs_n, spi_clk and mosi each pass through a 2-FF synchronizer.
- Edge detect: rise/fall pulses are 1 clk wide, taken from the synchronized SCK.
- MOSI is sampled on the SCK rise pulse; spi_miso updates on the SCK fall pulse.
- States: IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE.
- IDLE -> CMD on synchronized cs_n falling; bit_cnt=7; busy=1.
- CMD: after 8 rising edges, decode the opcode:
  - 0x03 READ -> ADDR.
  - 0x02 PROGRAM -> ADDR.
  - 0x05 RDSR -> STATUS.
  - 0x06 WREN -> set wel, go to IGNORE.
  - 0x04 WRDI -> clear wel, go to IGNORE.
  - any other opcode -> IGNORE.
- ADDR: collect 24 bits MSB first; on the 24th rise, addr_ptr <= addr[MEM_AW-1:0].
  - READ -> RD_DATA; preload tx_shift with mem[addr_ptr].
  - PROGRAM -> WR_DATA.
- RD_DATA:
  - bit7 of tx_shift drives spi_miso on the first fall pulse after the final address rise; the remaining bits follow on subsequent falls.
  - After the 8th bit is driven, addr_ptr increments, wrapping modulo 2**MEM_AW, and tx_shift reloads with the next byte.
  - Streaming continues while CS stays low.
- WR_DATA:
  - Every 8 rises assemble one byte.
  - If wel=1: write mem[addr_ptr], then increment addr_ptr with wrap.
  - If wel=0: discard the byte.
- STATUS: shift out {6'b0, wel, 1'b0} repeatedly on falls while CS stays low.
- IGNORE: ignore all SCK activity until CS rises.
- CS deassert (synchronized rise) in any state, at any bit:
  - abort to IDLE within 2 clk; busy=0; spi_miso=0.
  - A partial byte is discarded and never written.
  - If the aborted transaction was PROGRAM, clear wel, even if no byte completed.
- CS low with no SCK: remain in CMD indefinitely.
- Backdoor:
  - bd_we writes mem[bd_addr] on the clk edge.
  - bd_rdata <= mem[bd_addr] every cycle.
  - If a backdoor write and an SPI write hit the same cycle and address, the SPI write wins.
- Reset asserted mid-transaction: immediate return to reset values; memory is re-initialised to MEM_INIT.

Decomposition:
- spi_flash_pkg holds:
  - opcode constants OP_READ=8'h03, OP_PROG=8'h02, OP_RDSR=8'h05, OP_WREN=8'h06, OP_WRDI=8'h04;
  - the state enum typedef;
  - the status bit positions, WEL=1 and BUSY=0.
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall pulse generator, instantiated for SCK and cs_n; MOSI uses the synchronizer only.

Test Plan:
- Backdoor preload mem[0x10..0x13]=A5,5A,C3,3C; SPI READ opcode 03, addr 000010, 4 bytes -> MISO returns A5 5A C3 3C; addr_ptr ends at 0x14.
- WREN (06), then CS high; PROGRAM 02 addr 000020 with data 11 22 -> backdoor reads mem[0x20]=11 and mem[0x21]=22; wel=0 after CS rises.
- PROGRAM without a preceding WREN, data 77 to addr 000030 -> mem[0x30] stays FF.
- READ at addr 0000FF with 2 bytes, MEM_AW=8 -> returns mem[0xFF] then mem[0x00] (wrap).
- RDSR after WREN -> MISO byte 02; after WRDI -> 00.
- CS raised after 3 bits of a PROGRAM data byte -> no write occurs, state=IDLE within 2 clk, busy=0; a following READ completes correctly.
